// File: rtl/config_loader.sv
// Streams IN_W-bit bitstream words into CFG_W-bit rows, strobes each row
// into the fabric, then waits SETTLE_CYC cycles before enabling the fabric.
module config_loader #(
  parameter int CFG_W      = 384,
  parameter int NUM_ROWS   = 267,
  parameter int IN_W       = 32,
  parameter int SETTLE_CYC = 10
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                start,
  input  logic [IN_W-1:0]     in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [CFG_W-1:0]    configs_in,
  output logic [NUM_ROWS-1:0] configs_en,
  output logic                ff_en,
  output logic                rdy,
  output logic                busy
);

  localparam int WORDS = CFG_W / IN_W;
  localparam int WC_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int RC_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int SC_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int SC_LAST = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;

  localparam logic [WC_W-1:0] LAST_WORD   = WC_W'(WORDS - 1);
  localparam logic [RC_W-1:0] LAST_ROW    = RC_W'(NUM_ROWS - 1);
  localparam logic [SC_W-1:0] LAST_SETTLE = SC_W'(SC_LAST);

  typedef enum logic [2:0] {
    IDLE,
    ASSEMBLE,
    WRITE,
    SETTLE,
    DONE
  } state_t;

  state_t            state;
  logic [WC_W-1:0]   word_cnt;
  logic [RC_W-1:0]   row_idx;
  logic [SC_W-1:0]   settle_cnt;
  logic [CFG_W-1:0]  row_buf;
  logic [CFG_W-1:0]  row_next;
  logic              take;

  assign take = in_valid && in_ready;

  // Row as it will look once the current word lands in its slot
  always_comb begin
    row_next = row_buf;
    row_next[word_cnt*IN_W +: IN_W] = in_data;
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      word_cnt   <= '0;
      row_idx    <= '0;
      settle_cnt <= '0;
      row_buf    <= '0;
      in_ready   <= 1'b0;
      configs_in <= '0;
      configs_en <= '0;
      ff_en      <= 1'b0;
      rdy        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= ASSEMBLE;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            row_idx  <= '0;
            word_cnt <= '0;
          end
        end
        ASSEMBLE: begin
          if (take) begin
            row_buf <= row_next;
            if (word_cnt == LAST_WORD) begin
              state      <= WRITE;
              in_ready   <= 1'b0;
              configs_in <= row_next;
              configs_en <= NUM_ROWS'(1) << row_idx;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        WRITE: begin
          configs_en <= '0;
          word_cnt   <= '0;
          settle_cnt <= '0;
          if (row_idx == LAST_ROW) begin
            if (SETTLE_CYC == 0) begin
              state <= DONE;
              busy  <= 1'b0;
              ff_en <= 1'b1;
            end else begin
              state <= SETTLE;
            end
          end else begin
            row_idx  <= row_idx + 1'b1;
            state    <= ASSEMBLE;
            in_ready <= 1'b1;
          end
        end
        SETTLE: begin
          if (settle_cnt == LAST_SETTLE) begin
            state <= DONE;
            busy  <= 1'b0;
            ff_en <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        DONE: begin
          rdy <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 SHALL have parameter CFG_W, default 384, width of one configuration row (fabric configs_in width).
REQ-002 SHALL have parameter NUM_ROWS, default 267, number of configuration rows (fabric configs_en width).
REQ-003 SHALL have parameter IN_W, default 32, input word width; CFG_W SHALL be an integer multiple of IN_W.
REQ-004 SHALL have parameter SETTLE_CYC, default 10, idle cycles between the last row write and ff_en assertion.
REQ-005 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  single-cycle request to begin a configuration load.
REQ-008 SHALL have port in_data  input  IN_W  bitstream word.
REQ-009 SHALL have port in_valid  input  1  in_data valid.
REQ-010 SHALL have port in_ready  output  1  loader accepts a word this cycle.
REQ-011 SHALL have port configs_in  output  CFG_W  row data to the fabric.
REQ-012 SHALL have port configs_en  output  NUM_ROWS  one-hot row write strobe to the fabric.
REQ-013 SHALL have port ff_en  output  1  fabric flip-flop enable.
REQ-014 SHALL have port rdy  output  1  configuration complete, fabric usable.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE and DONE.

Function
REQ-016 SHALL implement states IDLE, ASSEMBLE, WRITE, SETTLE, DONE.
REQ-017 IDLE: in_ready=0; start=1 SHALL move to ASSEMBLE with row index 0 and word count 0.
REQ-018 A word SHALL transfer only on a cycle with in_valid=1 and in_ready=1; in_ready SHALL be 1 only in ASSEMBLE.
REQ-019 Word k (0-based) within a row SHALL occupy row bits [(k+1)*IN_W-1 : k*IN_W] (first word at LSBs).
REQ-020 On the transfer of word CFG_W/IN_W-1, the next state SHALL be WRITE.
REQ-021 WRITE lasts exactly one cycle: configs_in = assembled row, configs_en = one-hot bit at current row index; all other cycles configs_en SHALL be all-zero.
REQ-022 configs_in SHALL hold its last written value until the next WRITE (no glitching while assembling).
REQ-023 After WRITE: row index < NUM_ROWS-1 -> increment row index, clear word count, return to ASSEMBLE; row index = NUM_ROWS-1 -> SETTLE.
REQ-024 SETTLE SHALL last exactly SETTLE_CYC cycles, then move to DONE.
REQ-025 ff_en SHALL rise on the first DONE cycle; rdy SHALL rise one cycle later; both held high while in DONE.
REQ-026 start SHALL be ignored in every state except IDLE; DONE is left only by reset.
REQ-027 in_valid with in_data stalls (in_valid=0 mid-row) SHALL only pause assembly; no word lost or duplicated.
REQ-028 Word and row counters SHALL be sized to hold CFG_W/IN_W-1 and NUM_ROWS-1 without wrap; row index never exceeds NUM_ROWS-1.

Reset
REQ-029 rst=0 SHALL immediately and asynchronously force IDLE, configs_in=0, configs_en=0, ff_en=0, rdy=0, in_ready=0, busy=0, counters=0.
REQ-030 Reset asserted mid-load SHALL discard the partial row; no configs_en strobe SHALL occur during or after reset until a new start.
REQ-031 Outputs SHALL leave reset values only on clock edges after rst returns to 1.

Verification (CFG_W=64, IN_W=32, NUM_ROWS=3, SETTLE_CYC=4)
REQ-032 Full load: start, then words 0x11111111,0x22222222 (back-to-back) -> configs_in=0x2222222211111111 with configs_en=3'b001 for exactly one cycle; rows 1,2 strobe 3'b010, 3'b100; ff_en rises 4 cycles after the last WRITE cycle, rdy one cycle later.
REQ-033 Backpressure: in_valid toggled 1/0 every cycle -> identical configs_in/configs_en sequence to REQ-032, only delayed; in_ready=0 in every WRITE cycle.
REQ-034 Reset mid-row: after first word of row 1, rst=0 -> all outputs 0 immediately; restart and full reload -> same results as REQ-032.
REQ-035 Spurious start: start pulsed during ASSEMBLE and in DONE -> no state, counter or output change.
REQ-036 Idle input: in_valid=1 in IDLE with no start -> in_ready=0, configs_en stays 0, busy=0.
